qadd_rr_arbiter: RTL and testbench

//   Shares one sign-magnitude fixed-point adder among NREQ requesters.

---
 rtl/qadd_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_qadd_rr_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qadd_rr_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude fixed-point adder among NREQ lanes.
// A single result register gives one-cycle latency and full throughput while res_ready stays high.
module qadd_rr_arbiter #(
  parameter int Q    = 15,
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_c,
  output logic [IDW-1:0]    res_id,
  output logic              res_ovf
);

  // state | meaning
  // EMPTY | result register holds nothing; any request may be granted
  // FULL  | result register holds a sum awaiting res_ready

  localparam int M = N - 1;

  if (Q < 0 || Q >= N - 1 || NREQ < 2 || IDW != $clog2(NREQ)) begin : g_param_err
    $error("qadd_rr_arbiter: inconsistent parameters");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    gnt_idx;
  logic [IDW-1:0]    ptr_nxt;
  logic              gnt_found;
  logic              free;
  logic              xfer;
  logic [2*NREQ-1:0] req_rot;
  logic [IDW:0]      idx_sum;
  logic [IDW:0]      ptr_sum;

  logic [N-1:0] a_sel, b_sel, sum_c;
  logic         sum_ovf;
  logic         sa, sb, sgn;
  logic [M-1:0] ma, mb, mag;
  logic [M:0]   msum;

  // Rotating the doubled request vector puts lane ptr at bit 0, so the first set bit wins.
  assign req_rot = {req_valid, req_valid} >> ptr;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx_sum   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_found && req_rot[j]) begin
        gnt_found = 1'b1;
        idx_sum   = {1'b0, ptr} + (IDW+1)'(j);
        if (idx_sum >= (IDW+1)'(NREQ)) idx_sum = idx_sum - (IDW+1)'(NREQ);
        gnt_idx = idx_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    ptr_sum = {1'b0, gnt_idx} + (IDW+1)'(1);
    if (ptr_sum >= (IDW+1)'(NREQ)) ptr_sum = '0;
    ptr_nxt = ptr_sum[IDW-1:0];
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        a_sel = req_a[i*N +: N];
        b_sel = req_b[i*N +: N];
      end
    end
  end

  // Sign-magnitude add; -0 inputs fall out naturally as zero magnitude.
  always_comb begin
    sa   = a_sel[N-1];
    sb   = b_sel[N-1];
    ma   = a_sel[M-1:0];
    mb   = b_sel[M-1:0];
    msum = {1'b0, ma} + {1'b0, mb};
    if (sa == sb) begin
      mag     = msum[M-1:0];
      sgn     = sa;
      sum_ovf = msum[M];
    end else if (ma >= mb) begin
      mag     = ma - mb;
      sgn     = sa;
      sum_ovf = 1'b0;
    end else begin
      mag     = mb - ma;
      sgn     = sb;
      sum_ovf = 1'b0;
    end
    if (mag == '0) sgn = 1'b0;
    sum_c = {sgn, mag};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (xfer) state_nxt = FULL;
      FULL:  if (!xfer && res_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    res_valid = (state == FULL);
    free      = !res_valid || res_ready;
    req_ready = '0;
    if (!rst && free && gnt_found) req_ready[gnt_idx] = 1'b1;
    xfer = |req_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_c   <= '0;
      res_id  <= '0;
      res_ovf <= 1'b0;
      ptr     <= '0;
    end else if (xfer) begin
      res_c   <= sum_c;
      res_id  <= gnt_idx;
      res_ovf <= sum_ovf;
      ptr     <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_qadd_rr_arbiter.sv
// Bench for qadd_rr_arbiter: directed cases plus randomized traffic against an
// integer-arithmetic reference with a round-robin grant model.
module tb_qadd_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic         res_valid, res_ready;
  logic [31:0]  res_c;
  logic [1:0]   res_id;
  logic         res_ovf;

  int vectors = 0;
  int miscompares = 0;

  // reference state
  bit          m_valid;
  logic [31:0] m_c;
  int          m_id;
  bit          m_ovf;
  int          m_ptr;
  logic [3:0]  exp_ready;
  int          exp_g;

  qadd_rr_arbiter #(.Q(15), .N(32), .NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_c(res_c), .res_id(res_id), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  // Returns {ovf, sign, magnitude} from plain signed arithmetic on the operand values.
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    longint va, vb, s, mag;
    bit neg, ovf;
    va  = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    vb  = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    s   = va + vb;
    neg = (s < 0);
    mag = neg ? -s : s;
    ovf = (mag >= (longint'(1) << 31));
    if (ovf) mag = mag - (longint'(1) << 31);
    if (mag == 0) neg = 1'b0;
    return {ovf, neg, mag[30:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'h8000_0000;
      1: v = 32'h7FFF_FFFF;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h0000_0000;
      4: v = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 255))};
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic model_comb();
    exp_ready = 4'b0;
    exp_g     = -1;
    if (!rst && (!m_valid || res_ready)) begin
      for (int off = 0; off < 4; off++) begin
        if (exp_g < 0 && req_valid[(m_ptr + off) % 4]) exp_g = (m_ptr + off) % 4;
      end
    end
    if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
  endtask

  task automatic model_seq();
    logic [32:0] r;
    if (rst) begin
      m_valid = 0; m_c = 32'h0; m_id = 0; m_ovf = 0; m_ptr = 0;
    end else if (exp_g >= 0) begin
      r       = ref_add(req_a[exp_g*32 +: 32], req_b[exp_g*32 +: 32]);
      m_c     = r[31:0];
      m_ovf   = r[32];
      m_id    = exp_g;
      m_valid = 1;
      m_ptr   = (exp_g + 1) % 4;
    end else if (m_valid && res_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    model_comb();
  endtask

  task automatic to_pos();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; res_ready = 1'b1;
    req_a = {4{32'h0000_8000}}; req_b = {4{32'h0000_8000}};
    for (int k = 0; k < 2; k++) begin
      to_neg();
      vectors++;
      if (req_ready !== 4'b0) begin
        miscompares++;
        $display("FAIL reset_ready cyc=%0d got %b want 0000", k, req_ready);
      end
      to_pos();
    end
    vectors++;
    if ({res_valid, res_c, res_id, res_ovf} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got v=%b c=%h id=%0d ovf=%b want all zero", res_valid, res_c, res_id, res_ovf);
    end
    rst = 1'b0; req_valid = 4'h0;
  endtask

  task automatic test_arith();
    int          lane [5] = '{0, 2, 2, 1, 1};
    logic [31:0] av   [5] = '{32'h0001_8000, 32'h0000_8000, 32'h8000_4000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bv   [5] = '{32'h8000_8000, 32'h8000_8000, 32'h0000_2000, 32'h0000_0001, 32'h8000_0001};
    logic [31:0] cv   [5] = '{32'h0001_0000, 32'h0000_0000, 32'h8000_2000, 32'h0000_0000, 32'h0000_0000};
    logic        ov   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  want;
    res_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      want = 4'b1 << lane[t];
      req_valid = want;
      set_lane(lane[t], av[t], bv[t]);
      to_neg();
      vectors++;
      if (req_ready !== want) begin
        miscompares++;
        $display("FAIL arith_grant t=%0d got %b want %b", t, req_ready, want);
      end
      to_pos();
      req_valid = 4'h0;
      vectors++;
      if (res_valid !== 1'b1 || res_c !== cv[t] || res_id !== 2'(lane[t]) || res_ovf !== ov[t]) begin
        miscompares++;
        $display("FAIL arith_result t=%0d got v=%b c=%h id=%0d ovf=%b want v=1 c=%h id=%0d ovf=%b",
                 t, res_valid, res_c, res_id, res_ovf, cv[t], lane[t], ov[t]);
      end
      to_neg();
      to_pos();
      vectors++;
      if (res_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL arith_drain t=%0d got v=%b want 0", t, res_valid);
      end
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1; to_neg(); to_pos(); rst = 1'b0;
    for (int i = 0; i < 4; i++) set_lane(i, $urandom, $urandom);
    req_valid = 4'hF; res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      to_neg();
      vectors++;
      if (req_ready !== 4'(4'b1 << (k % 4))) begin
        miscompares++;
        $display("FAIL rr_grant k=%0d got %b want %b", k, req_ready, 4'(4'b1 << (k % 4)));
      end
      to_pos();
      vectors++;
      if (res_valid !== 1'b1 || res_id !== 2'(k % 4) || res_c !== m_c || res_ovf !== m_ovf) begin
        miscompares++;
        $display("FAIL rr_result k=%0d got v=%b id=%0d c=%h ovf=%b want v=1 id=%0d c=%h ovf=%b",
                 k, res_valid, res_id, res_c, res_ovf, k % 4, m_c, m_ovf);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_c;
    int          held_id;
    held_c  = m_c;
    held_id = m_id;
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      to_neg();
      vectors++;
      if (req_ready !== 4'b0) begin
        miscompares++;
        $display("FAIL bp_ready k=%0d got %b want 0000", k, req_ready);
      end
      to_pos();
      vectors++;
      if (res_valid !== 1'b1 || res_c !== held_c || res_id !== 2'(held_id)) begin
        miscompares++;
        $display("FAIL bp_hold k=%0d got v=%b c=%h id=%0d want v=1 c=%h id=%0d",
                 k, res_valid, res_c, res_id, held_c, held_id);
      end
    end
    res_ready = 1'b1;
    to_neg();
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL bp_release_grant got %b want 0001", req_ready);
    end
    to_pos();
    req_valid = 4'h0;
    vectors++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 || res_c !== m_c) begin
      miscompares++;
      $display("FAIL bp_release_result got v=%b id=%0d c=%h want v=1 id=0 c=%h", res_valid, res_id, res_c, m_c);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; to_neg(); to_pos(); rst = 1'b0;
    req_valid = 4'b0010; res_ready = 1'b0;
    set_lane(1, 32'h0000_8000, 32'h0000_8000);
    to_neg(); to_pos();
    req_valid = 4'h0;
    vectors++;
    if (res_valid !== 1'b1 || res_id !== 2'd1 || res_c !== 32'h0001_0000) begin
      miscompares++;
      $display("FAIL rstmid_setup got v=%b id=%0d c=%h want v=1 id=1 c=00010000", res_valid, res_id, res_c);
    end
    rst = 1'b1; req_valid = 4'hF;
    to_neg();
    vectors++;
    if (req_ready !== 4'b0) begin
      miscompares++;
      $display("FAIL rstmid_ready got %b want 0000", req_ready);
    end
    to_pos();
    vectors++;
    if ({res_valid, res_c, res_id, res_ovf} !== 36'h0) begin
      miscompares++;
      $display("FAIL rstmid_outputs got v=%b c=%h id=%0d ovf=%b want all zero", res_valid, res_c, res_id, res_ovf);
    end
    rst = 1'b0; req_valid = 4'b1001; res_ready = 1'b1;
    to_neg();
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL rstmid_first_grant got %b want 0001", req_ready);
    end
    to_pos();
    req_valid = 4'h0;
    vectors++;
    if (res_valid !== 1'b1 || res_id !== 2'd0) begin
      miscompares++;
      $display("FAIL rstmid_first_result got v=%b id=%0d want v=1 id=0", res_valid, res_id);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 4; i++) begin
        if (exp_ready[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          a = rnd_op();
          set_lane(i, a, ($urandom_range(0, 4) == 0) ? {~a[31], a[30:0]} : rnd_op());
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      to_neg();
      vectors++;
      if (req_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL rand_grant k=%0d got %b want %b", k, req_ready, exp_ready);
      end
      to_pos();
      vectors++;
      if (res_valid !== m_valid ||
          (m_valid && (res_c !== m_c || res_id !== 2'(m_id) || res_ovf !== m_ovf))) begin
        miscompares++;
        $display("FAIL rand_result k=%0d got v=%b c=%h id=%0d ovf=%b want v=%b c=%h id=%0d ovf=%b",
                 k, res_valid, res_c, res_id, res_ovf, m_valid, m_c, m_id, m_ovf);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_valid = 0; m_c = 32'h0; m_id = 0; m_ovf = 0; m_ptr = 0;
    exp_ready = 4'h0; exp_g = -1;
    test_reset();
    test_arith();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
